hdc_temporal_fuser: RTL and testbench
=====================================

# hdc_temporal_fuser

Parametrised N-modality temporal encoder with optional early-fusion output. It sits between the spatial encoder and the associative memory, and replaces the fixed three-instance temporal stage with one block that has a single shared handshake. Each accepted spatial sample holds one hypervector per modality. The block forms an NGRAM-length temporal n-gram per modality, and in early mode it also emits a bitwise-majority bundle across modalities.

## Interface
- HV_DIM, default `HV_DIMENSION: hypervector width in bits.
- N_MOD, default 3: number of modalities, ≥1.
- NGRAM, default 3: n-gram length in samples, ≥2.
- CNT_W, default $clog2(NGRAM): width of the fill counter.
- Clk_CI  in  1: the single clock; all state changes on its rising edge.
- Reset_RI  in  1: synchronous, active-high reset.
- ValidIn_SI  in  1: input sample valid.
- ReadyOut_SO  out  1: block can accept a sample.
- HypervectorIn_DI  in  N_MOD*HV_DIM: spatial hypervectors. Modality m occupies bits [m*HV_DIM : m*HV_DIM+HV_DIM-1], using [0:W-1] ordering.
- FusionMode_SI  in  1: 0 = late (per-modality only), 1 = early (fused bundle also produced). Sampled on accept.
- Flush_SI  in  1: clears temporal history.
- ValidOut_SO  out  1: output valid.
- ReadyIn_SI  in  1: downstream ready.
- HypervectorOut_DO  out  N_MOD*HV_DIM: per-modality n-grams, same packing as the input.
- FusedOut_DO  out  HV_DIM: majority bundle; all zeros when the captured mode is late.
- FusedValid_SO  out  1: captured mode of the current output; meaningful only while ValidOut_SO is high.

## Operation
- **Accept condition:** ValidIn_SI & ReadyOut_SO & ~Flush_SI.
- **ReadyOut_SO** = ~Reset_RI & ~Flush_SI & (~ValidOut_SO | ReadyIn_SI). This is combinational and gives full-throughput pass-through.
- **History storage:** per modality, registers H1..H(NGRAM-1). On accept:
  - H1 <= input.
  - Hk <= H(k-1).
- **Rotation:** rho^k(x) is a rotate right by k bits, so rho^k(x)[i] = x[(i-k) mod HV_DIM].
- **N-gram:** ngram_m = in_m ^ rho^1(H1_m) ^ rho^2(H2_m) ^ … ^ rho^(NGRAM-1)(H(NGRAM-1)_m).
- **Fill counter:**
  - Incremented on accept; saturates at NGRAM-1.
  - An accept with fill == NGRAM-1 is a "full" accept.
  - Earlier accepts only load history and produce no output.
- **Output register:**
  - Loaded on a full accept: HypervectorOut_DO <= ngrams, FusedValid_SO <= mode.
  - FusedOut_DO <= (mode ? majority : 0).
- **Majority:**
  - Per bit, set when more than N_MOD/2 of the modalities have the bit set.
  - For even N_MOD, a tie takes the modality-0 bit.
- **ValidOut_SO:**
  - Set by a full accept.
  - Cleared when ValidOut_SO & ReadyIn_SI and there is no full accept in the same cycle.
  - Output data is stable while ValidOut_SO & ~ReadyIn_SI.
- **Flush_SI:**
  - Clears the fill counter and all history to zero.
  - A sample presented in the same cycle is not accepted (ReadyOut_SO is low).
  - A pending output is retained until it is consumed.
- **Reset:** see Timing. A reset mid-operation discards all history and any pending output.

## Timing
- Reset values: ValidOut_SO=0, FusedValid_SO=0, HypervectorOut_DO=0, FusedOut_DO=0, fill=0, history=0. ReadyOut_SO=0 while Reset_RI is high.
- Latency: a full accept at edge t gives ValidOut_SO high after edge t, i.e. one cycle.
- Warm-up: the first output follows the NGRAM-th accept after reset or flush.
- Steady state: one output per accept.
- Simultaneous consume and full accept: the output register reloads and ValidOut_SO stays high. There is no bubble.
- Backpressure: while ValidOut_SO & ~ReadyIn_SI, ReadyOut_SO=0, so neither history nor the counter advances.
- Fill counter: never wraps; it holds at NGRAM-1.

## Structure
- Shared package or `const.vh` holds:
  - defaults for HV_DIM, N_MOD, NGRAM;
  - mode encodings FUSION_LATE=0 and FUSION_EARLY=1.
- One sub-module, hdc_ngram_lane, instantiated N_MOD times via generate. It contains:
  - the history shift registers;
  - the rotate/XOR tree;
  - shift-enable and clear inputs.
- The top level contains:
  - the fill counter;
  - the handshake logic;
  - the majority bundler;
  - the output register.

## Test plan
All scenarios use HV_DIM=8, N_MOD=3, NGRAM=3; hex values are written in [0:7] order with bit 0 as the MSB.
1. **Warm-up and rotation:**
   - Stimulus: mod0 inputs 0x80, 0x00, 0x00 on consecutive cycles, ReadyIn_SI=1.
   - Response: ValidOut_SO low after the first two accepts, then high for one cycle with mod0 out = 0x20.
2. **Majority:**
   - Stimulus: after flush, warm up with two zero samples, then send mod0/1/2 = 0xF0/0xCC/0xAA with FusionMode_SI=1.
   - Response: per-lane outputs 0xF0/0xCC/0xAA, FusedOut_DO=0xE8, FusedValid_SO=1.
   - Same sequence with FusionMode_SI=0 gives FusedOut_DO=0x00.
3. **Backpressure:**
   - Stimulus: hold ReadyIn_SI=0 with ValidIn_SI=1 continuously.
   - Response: after the first output, ReadyOut_SO=0 and the data holds for 5 cycles.
   - Release: raising ReadyIn_SI consumes the held output; the next sample is accepted the same cycle and its output appears one cycle later, with no lost or duplicated sample.
4. **Flush:**
   - Stimulus: after a steady-state stream, assert Flush_SI together with ValidIn_SI.
   - Response: that sample is rejected and the pending output is still delivered.
   - The next 2 accepts produce no output; the 3rd does.
5. **Reset mid-operation:**
   - Stimulus: assert Reset_RI while ValidOut_SO=1 and ReadyIn_SI=0.
   - Response: next cycle all outputs are zero and ReadyOut_SO=0.
   - After release, warm-up restarts (3 accepts before the first output).
6. **Throughput:**
   - Stimulus: 20 back-to-back samples with ReadyIn_SI=1.
   - Response: 18 outputs on consecutive cycles, matching a reference model.

Source files
------------

// File: rtl/hdc_temporal_fuser_pkg.sv
// hdc_temporal_fuser_pkg: shared defaults and fusion mode encodings for the temporal fuser.
package hdc_temporal_fuser_pkg;
  localparam int HV_DIMENSION = 2048;
  localparam int N_MOD_DEF = 3;
  localparam int NGRAM_DEF = 3;
  typedef enum logic {
    FUSION_LATE  = 1'b0,
    FUSION_EARLY = 1'b1
  } fusion_mode_e;
endpackage

// File: rtl/hdc_temporal_fuser_if.sv
// hdc_temporal_fuser_if: shared input/output handshake bundle of the temporal fuser.
interface hdc_temporal_fuser_if
  import hdc_temporal_fuser_pkg::*;
#(
  parameter int HV_DIM = HV_DIMENSION,
  parameter int N_MOD  = N_MOD_DEF
);
  logic                      ValidIn_SI;
  logic                      ReadyOut_SO;
  logic [0:N_MOD*HV_DIM-1]   HypervectorIn_DI;
  logic                      FusionMode_SI;
  logic                      Flush_SI;
  logic                      ValidOut_SO;
  logic                      ReadyIn_SI;
  logic [0:N_MOD*HV_DIM-1]   HypervectorOut_DO;
  logic [0:HV_DIM-1]         FusedOut_DO;
  logic                      FusedValid_SO;
  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, FusionMode_SI, Flush_SI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, FusedOut_DO, FusedValid_SO
  );
  modport master (
    output ValidIn_SI, HypervectorIn_DI, FusionMode_SI, Flush_SI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, FusedOut_DO, FusedValid_SO
  );
endinterface

// File: rtl/hdc_ngram_lane.sv
// hdc_ngram_lane: one modality's history shift chain and rotate/XOR n-gram tree.
module hdc_ngram_lane
  import hdc_temporal_fuser_pkg::*;
#(
  parameter int HV_DIM = HV_DIMENSION,
  parameter int NGRAM  = NGRAM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic [0:HV_DIM-1] hv_i,
  output logic [0:HV_DIM-1] ngram_o
);
  logic [0:HV_DIM-1] hist_q [1:NGRAM-1];
  logic [0:HV_DIM-1] rot    [1:NGRAM-1];
  logic [0:HV_DIM-1] acc;
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      hist_q <= '{default: '0};
    end else if (shift_en_i) begin
      hist_q[1] <= hv_i;
      for (int k = 2; k < NGRAM; k++) hist_q[k] <= hist_q[k-1];
    end
  end
  // H_k is rotated right by k: doubling the word turns the rotate into a fixed slice
  for (genvar k = 1; k < NGRAM; k++) begin : g_rot
    logic [0:2*HV_DIM-1] dbl;
    assign dbl    = {hist_q[k], hist_q[k]};
    assign rot[k] = dbl[HV_DIM-(k%HV_DIM) +: HV_DIM];
  end
  always_comb begin
    acc = hv_i;
    for (int k = 1; k < NGRAM; k++) acc = acc ^ rot[k];
  end
  assign ngram_o = acc;
endmodule

// File: rtl/hdc_temporal_fuser.sv
// hdc_temporal_fuser: N-modality temporal n-gram encoder with optional majority early fusion.
module hdc_temporal_fuser
  import hdc_temporal_fuser_pkg::*;
#(
  parameter int HV_DIM = HV_DIMENSION,
  parameter int N_MOD  = N_MOD_DEF,
  parameter int NGRAM  = NGRAM_DEF,
  parameter int CNT_W  = $clog2(NGRAM)
) (
  input logic                 Clk_CI,
  input logic                 Reset_RI,
  hdc_temporal_fuser_if.slave bus
);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM - 1);
  logic                    ready, accept, full_acc, early;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic [0:N_MOD*HV_DIM-1] ngram, hv_q, hv_d;
  logic [0:HV_DIM-1]       maj, fused_q, fused_d;
  logic                    valid_q, valid_d, fmode_q, fmode_d;
  int                      cnt;
  assign ready    = ~Reset_RI & ~bus.Flush_SI & (~valid_q | bus.ReadyIn_SI);
  assign accept   = bus.ValidIn_SI & ready;
  assign full_acc = accept & (fill_q == FILL_MAX);
  assign early    = fusion_mode_e'(bus.FusionMode_SI) == FUSION_EARLY;
  for (genvar m = 0; m < N_MOD; m++) begin : g_lane
    hdc_ngram_lane #(.HV_DIM(HV_DIM), .NGRAM(NGRAM)) u_lane (
      .clk       (Clk_CI),
      .rst       (Reset_RI),
      .shift_en_i(accept),
      .clear_i   (bus.Flush_SI),
      .hv_i      (bus.HypervectorIn_DI[m*HV_DIM +: HV_DIM]),
      .ngram_o   (ngram[m*HV_DIM +: HV_DIM])
    );
  end
  // an exact tie (even N_MOD only) falls back to the modality-0 bit
  always_comb begin
    maj = '0;
    cnt = 0;
    for (int i = 0; i < HV_DIM; i++) begin
      cnt = 0;
      for (int m = 0; m < N_MOD; m++) cnt = cnt + int'(ngram[m*HV_DIM+i]);
      maj[i] = (2*cnt > N_MOD) | ((2*cnt == N_MOD) & ngram[i]);
    end
  end
  always_comb begin
    fill_d  = bus.Flush_SI ? '0 : (accept & ~full_acc) ? fill_q + 1'b1 : fill_q;
    valid_d = full_acc | (valid_q & ~bus.ReadyIn_SI);
    hv_d    = full_acc ? ngram : hv_q;
    fmode_d = full_acc ? early : fmode_q;
    fused_d = full_acc ? (early ? maj : '0) : fused_q;
  end
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      fill_q  <= '0;
      valid_q <= 1'b0;
      hv_q    <= '0;
      fmode_q <= 1'b0;
      fused_q <= '0;
    end else begin
      fill_q  <= fill_d;
      valid_q <= valid_d;
      hv_q    <= hv_d;
      fmode_q <= fmode_d;
      fused_q <= fused_d;
    end
  end
  assign bus.ReadyOut_SO       = ready;
  assign bus.ValidOut_SO       = valid_q;
  assign bus.HypervectorOut_DO = hv_q;
  assign bus.FusedOut_DO       = fused_q;
  assign bus.FusedValid_SO     = fmode_q;
endmodule

// File: tb/tb_hdc_temporal_fuser.sv
// tb_hdc_temporal_fuser: vector table, directed corner sequences and random traffic against a sample-history model.
module tb_hdc_temporal_fuser;
  localparam int W = 8, N = 3, G = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hdc_temporal_fuser_if #(.HV_DIM(W), .N_MOD(N)) bus ();
  hdc_temporal_fuser #(.HV_DIM(W), .N_MOD(N), .NGRAM(G)) dut (
    .Clk_CI  (clk),
    .Reset_RI(rst),
    .bus     (bus)
  );
  logic [0:N*W-1] hq[$];
  logic           ev = 1'b0, efv = 1'b0;
  logic [0:N*W-1] ehv = '0;
  logic [0:W-1]   ef = '0;
  int n_chk = 0, n_fail = 0, vcount = 0;
  typedef struct {
    logic         vin, fl, md;
    logic [0:N*W-1] hv;
    logic         ev;
    logic [0:N*W-1] ehv;
    logic [0:W-1] ef;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [0:W-1] rot(input logic [0:W-1] x, input int k);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) r[i] = x[((i - k) % W + W) % W];
    return r;
  endfunction
  function automatic logic [0:W-1] majority(input logic [0:N*W-1] v);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) begin
      int c = 0;
      for (int m = 0; m < N; m++) c += int'(v[m*W+i]);
      r[i] = (2*c > N) || (2*c == N && v[i]);
    end
    return r;
  endfunction
  function automatic logic [0:N*W-1] rnd();
    return (N*W)'($urandom);
  endfunction
  // one clock: drive, check ready mid-cycle, advance the model, check registered outputs
  task automatic cycle(input logic r, vin, fl, md, rd, input logic [0:N*W-1] hv);
    logic exp_rdy, acc, full;
    logic [0:N*W-1] ng;
    rst = r;
    bus.ValidIn_SI = vin;
    bus.Flush_SI = fl;
    bus.FusionMode_SI = md;
    bus.ReadyIn_SI = rd;
    bus.HypervectorIn_DI = hv;
    #4;
    exp_rdy = !r && !fl && (!ev || rd);
    chk("ready", {31'b0, bus.ReadyOut_SO}, {31'b0, exp_rdy});
    acc = vin && exp_rdy;
    full = acc && hq.size() == G - 1;
    ng = hv;
    if (full)
      for (int k = 1; k < G; k++)
        for (int m = 0; m < N; m++) ng[m*W +: W] = ng[m*W +: W] ^ rot(hq[k-1][m*W +: W], k);
    @(posedge clk);
    #1;
    if (r) begin
      hq.delete();
      ev = 0; efv = 0; ehv = '0; ef = '0;
    end else begin
      if (full) begin
        ehv = ng; efv = md; ef = md ? majority(ng) : '0; ev = 1;
      end else if (ev && rd) ev = 0;
      if (acc) begin
        hq.push_front(hv);
        if (hq.size() > G - 1) void'(hq.pop_back());
      end
      if (fl) hq.delete();
    end
    chk("valid", {31'b0, bus.ValidOut_SO}, {31'b0, ev});
    chk("hv_out", {8'b0, bus.HypervectorOut_DO}, {8'b0, ehv});
    chk("fused", {24'b0, bus.FusedOut_DO}, {24'b0, ef});
    chk("fused_valid", {31'b0, bus.FusedValid_SO}, {31'b0, efv});
    if (bus.ValidOut_SO) vcount++;
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 24'h800000, 0, 24'h000000, 8'h00};
    tbl[1]  = '{1, 0, 0, 24'h000000, 0, 24'h000000, 8'h00};
    tbl[2]  = '{1, 0, 0, 24'h000000, 1, 24'h200000, 8'h00};
    tbl[3]  = '{0, 1, 0, 24'h000000, 0, 24'h200000, 8'h00};
    tbl[4]  = '{1, 0, 1, 24'h000000, 0, 24'h200000, 8'h00};
    tbl[5]  = '{1, 0, 1, 24'h000000, 0, 24'h200000, 8'h00};
    tbl[6]  = '{1, 0, 1, 24'hF0CCAA, 1, 24'hF0CCAA, 8'hE8};
    tbl[7]  = '{0, 1, 0, 24'h000000, 0, 24'hF0CCAA, 8'hE8};
    tbl[8]  = '{1, 0, 0, 24'h000000, 0, 24'hF0CCAA, 8'hE8};
    tbl[9]  = '{1, 0, 0, 24'h000000, 0, 24'hF0CCAA, 8'hE8};
    tbl[10] = '{1, 0, 0, 24'hF0CCAA, 1, 24'hF0CCAA, 8'h00};
    cycle(1, 0, 0, 0, 1, '0);
    cycle(1, 1, 0, 0, 1, '0);
    for (int i = 0; i < 11; i++) begin
      cycle(0, tbl[i].vin, tbl[i].fl, tbl[i].md, 1, tbl[i].hv);
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus.ValidOut_SO}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_hv", i), {8'b0, bus.HypervectorOut_DO}, {8'b0, tbl[i].ehv});
      chk($sformatf("tbl%0d_fused", i), {24'b0, bus.FusedOut_DO}, {24'b0, tbl[i].ef});
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 1, 0, rnd());
      chk("bp_ready_low", {31'b0, bus.ReadyOut_SO}, 32'd0);
    end
    vcount = 0;
    cycle(0, 1, 0, 1, 1, rnd());
    chk("bp_release_valid", {31'b0, bus.ValidOut_SO}, 32'd1);
    cycle(0, 0, 0, 0, 1, '0);
    chk("bp_release_count", vcount, 32'd1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, $urandom_range(0, 1), 1, rnd());
    cycle(0, 1, 1, 0, 0, rnd());
    chk("flush_pending", {31'b0, bus.ValidOut_SO}, 32'd1);
    cycle(0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, 0, rnd());
      chk($sformatf("flush_warm%0d", i), {31'b0, bus.ValidOut_SO}, {31'b0, i == 2});
    end
    cycle(0, 1, 0, 0, 0, rnd());
    cycle(1, 1, 0, 0, 0, rnd());
    chk("rst_valid", {31'b0, bus.ValidOut_SO}, 32'd0);
    chk("rst_hv", {8'b0, bus.HypervectorOut_DO}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 1, rnd());
      chk($sformatf("rst_warm%0d", i), {31'b0, bus.ValidOut_SO}, {31'b0, i == 2});
    end
    cycle(0, 0, 1, 0, 1, '0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, $urandom_range(0, 1), 1, rnd());
      chk($sformatf("tp_valid%0d", i), {31'b0, bus.ValidOut_SO}, {31'b0, i >= 2});
    end
    chk("tp_count", vcount, 32'd18);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 1), $urandom_range(0, 2) != 0, rnd());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
